// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared state encodings and arbitration helper for mem_port_arbiter
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_IWAIT = 2'd1,
        ARB_DWAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_e;

    // Data belongs to the older instruction, so it wins ties unless fetch has been starved.
    function automatic req_id_e pick_winner(input logic if_req, input logic d_req,
                                            input logic starved);
        return (d_req && !(if_req && starved)) ? REQ_D : REQ_IF;
    endfunction

endpackage

// File: rtl/mem_watchdog.sv
// rtl/mem_watchdog.sv - wait-cycle counter that flags an access stuck past TIMEOUT edges
module mem_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          at_last;

    assign at_last = (cnt_q == LAST);
    assign expired = (TIMEOUT != 0) && en && at_last;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !at_last) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-ported memory between fetch and load/store
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = 16,
    parameter int MAX_DGRANT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_be,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int SW = $clog2(MAX_DGRANT) + 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_DGRANT);

    arb_state_e        state_q, state_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              if_gnt_q, if_gnt_d, if_valid_q, if_valid_d, if_err_q, if_err_d;
    logic              d_gnt_q, d_gnt_d, d_valid_q, d_valid_d, d_err_q, d_err_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic              waiting, wd_expired;
    req_id_e           winner;

    assign waiting = (state_q != ARB_IDLE);

    mem_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (!waiting),
        .en      (waiting && !mem_ready),
        .expired (wd_expired)
    );

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        if_gnt_d    = 1'b0;
        if_valid_d  = 1'b0;
        if_err_d    = 1'b0;
        d_gnt_d     = 1'b0;
        d_valid_d   = 1'b0;
        d_err_d     = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        winner      = pick_winner(if_req, d_req, starve_q == STARVE_MAX);

        unique case (state_q)
            ARB_IDLE: begin
                if (if_req || d_req) begin
                    mem_req_d = 1'b1;
                    if (winner == REQ_D) begin
                        d_gnt_d     = 1'b1;
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        mem_be_d    = d_be;
                        state_d     = ARB_DWAIT;
                        if (if_req && starve_q != STARVE_MAX) begin
                            starve_d = starve_q + SW'(1);
                        end
                    end else begin
                        if_gnt_d   = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = if_addr;
                        mem_be_d   = 4'hF;
                        state_d    = ARB_IWAIT;
                        starve_d   = '0;
                    end
                end
            end
            ARB_IWAIT, ARB_DWAIT: begin
                // wd_expired already implies mem_ready is low, so ready always wins the race.
                if (mem_ready || wd_expired) begin
                    mem_req_d = 1'b0;
                    state_d   = ARB_IDLE;
                    if (state_q == ARB_IWAIT) begin
                        if_valid_d = 1'b1;
                        if_err_d   = !mem_ready;
                        if (mem_ready) begin
                            if_rdata_d = mem_rdata;
                        end
                    end else begin
                        d_valid_d = 1'b1;
                        d_err_d   = !mem_ready;
                        if (mem_ready && !mem_we_q) begin
                            d_rdata_d = mem_rdata;
                        end
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ARB_IDLE;
            starve_q    <= '0;
            if_gnt_q    <= 1'b0;
            if_valid_q  <= 1'b0;
            if_err_q    <= 1'b0;
            if_rdata_q  <= '0;
            d_gnt_q     <= 1'b0;
            d_valid_q   <= 1'b0;
            d_err_q     <= 1'b0;
            d_rdata_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            if_gnt_q    <= if_gnt_d;
            if_valid_q  <= if_valid_d;
            if_err_q    <= if_err_d;
            if_rdata_q  <= if_rdata_d;
            d_gnt_q     <= d_gnt_d;
            d_valid_q   <= d_valid_d;
            d_err_q     <= d_err_d;
            d_rdata_q   <= d_rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
        end
    end

    assign if_gnt    = if_gnt_q;
    assign if_valid  = if_valid_q;
    assign if_err    = if_err_q;
    assign if_rdata  = if_rdata_q;
    assign d_gnt     = d_gnt_q;
    assign d_valid   = d_valid_q;
    assign d_err     = d_err_q;
    assign d_rdata   = d_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign busy      = waiting;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int TO = 16;
    localparam int MD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we, mem_ready;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]  d_be;
    logic        if_gnt, if_valid, if_err, d_gnt, d_valid, d_err;
    logic        mem_req, mem_we, busy;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT(TO), .MAX_DGRANT(MD)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid),
        .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
    );

    int vectors = 0;
    int miscompares = 0;
    int n_checks = 0;

    // Reference model: who owns the memory, how long it has waited, fetch starvation.
    int          m_owner = 0;
    int          m_age = 0;
    int          m_starve = 0;
    logic        m_we = 1'b0;
    logic        e_if_gnt, e_if_valid, e_if_err, e_d_gnt, e_d_valid, e_d_err;
    logic        e_mem_req, e_mem_we, e_busy, e_chk_wbe;
    logic [31:0] e_if_rdata, e_d_rdata, e_mem_addr, e_mem_wdata;
    logic [3:0]  e_mem_be;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_next();
        e_if_gnt = 1'b0; e_if_valid = 1'b0; e_if_err = 1'b0;
        e_d_gnt = 1'b0;  e_d_valid = 1'b0;  e_d_err = 1'b0;
        if (!rst) begin
            m_owner = 0; m_age = 0; m_starve = 0; m_we = 1'b0;
            e_if_rdata = '0; e_d_rdata = '0; e_mem_req = 1'b0; e_mem_we = 1'b0;
            e_mem_addr = '0; e_mem_wdata = '0; e_mem_be = '0; e_chk_wbe = 1'b1;
        end else if (m_owner == 0) begin
            if (d_req && !(if_req && m_starve == MD)) begin
                m_owner = 2; m_we = d_we; e_d_gnt = 1'b1;
                e_mem_req = 1'b1; e_mem_we = d_we; e_mem_addr = d_addr;
                e_mem_wdata = d_wdata; e_mem_be = d_be; e_chk_wbe = 1'b1;
                if (if_req && m_starve < MD) m_starve++;
                m_age = 0;
            end else if (if_req) begin
                m_owner = 1; m_we = 1'b0; e_if_gnt = 1'b1;
                e_mem_req = 1'b1; e_mem_we = 1'b0; e_mem_addr = if_addr; e_chk_wbe = 1'b0;
                m_starve = 0; m_age = 0;
            end
        end else if (mem_ready || (TO > 0 && m_age == TO - 1)) begin
            if (m_owner == 1) begin
                e_if_valid = 1'b1; e_if_err = !mem_ready;
                if (mem_ready) e_if_rdata = mem_rdata;
            end else begin
                e_d_valid = 1'b1; e_d_err = !mem_ready;
                if (mem_ready && !m_we) e_d_rdata = mem_rdata;
            end
            m_owner = 0; e_mem_req = 1'b0;
        end else begin
            m_age++;
        end
        e_busy = (m_owner != 0);
    endtask

    task automatic compare_all();
        chk("if_gnt", 32'(if_gnt), 32'(e_if_gnt));
        chk("if_valid", 32'(if_valid), 32'(e_if_valid));
        chk("if_err", 32'(if_err), 32'(e_if_err));
        chk("if_rdata", if_rdata, e_if_rdata);
        chk("d_gnt", 32'(d_gnt), 32'(e_d_gnt));
        chk("d_valid", 32'(d_valid), 32'(e_d_valid));
        chk("d_err", 32'(d_err), 32'(e_d_err));
        chk("d_rdata", d_rdata, e_d_rdata);
        chk("mem_req", 32'(mem_req), 32'(e_mem_req));
        chk("mem_we", 32'(mem_we), 32'(e_mem_we));
        chk("mem_addr", mem_addr, e_mem_addr);
        chk("busy", 32'(busy), 32'(e_busy));
        if (e_chk_wbe) begin
            chk("mem_wdata", mem_wdata, e_mem_wdata);
            chk("mem_be", 32'(mem_be), 32'(e_mem_be));
        end
    endtask

    task automatic step();
        model_next();
        @(negedge clk);
        vectors++;
        compare_all();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int cnt1, cnt2, seen_if, stall_left;
        rst = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0; mem_rdata = '0;
        step(); step();
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b1;
        step();

        // Lone fetch
        if_req = 1'b1; if_addr = 32'h10;
        step();
        chk("lone_if_gnt", 32'(if_gnt), 1);
        chk("lone_mem_addr", mem_addr, 32'h10);
        chk("lone_busy", 32'(busy), 1);
        if_req = 1'b0;
        step();
        chk("lone_gnt_pulse", 32'(if_gnt), 0);
        step();
        chk("lone_mem_req_held", 32'(mem_req), 1);
        mem_ready = 1'b1; mem_rdata = 32'h0050_0093;
        step();
        chk("lone_if_valid", 32'(if_valid), 1);
        chk("lone_if_rdata", if_rdata, 32'h0050_0093);
        chk("lone_if_err", 32'(if_err), 0);
        chk("lone_mem_req_drop", 32'(mem_req), 0);
        mem_ready = 1'b0;
        step();
        chk("lone_valid_pulse", 32'(if_valid), 0);

        // Tie: store wins, fetch follows on the next IDLE edge
        if_req = 1'b1; if_addr = 32'h20;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_be = 4'hF;
        step();
        chk("tie_d_gnt", 32'(d_gnt), 1);
        chk("tie_if_gnt", 32'(if_gnt), 0);
        chk("tie_mem_we", 32'(mem_we), 1);
        chk("tie_mem_addr", mem_addr, 32'h100);
        chk("tie_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        d_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
        step();
        chk("tie_d_valid", 32'(d_valid), 1);
        chk("tie_d_rdata_kept", d_rdata, 32'h0);
        mem_ready = 1'b0;
        step();
        chk("tie_if_gnt_next", 32'(if_gnt), 1);
        chk("tie_if_addr", mem_addr, 32'h20);
        if_req = 1'b0; mem_ready = 1'b1;
        step();
        chk("tie_if_rdata", if_rdata, 32'hCAFE_F00D);
        mem_ready = 1'b0;
        step();

        // Starvation: four data grants, then fetch, then four more
        if_req = 1'b1; if_addr = 32'h30; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
        mem_ready = 1'b1; mem_rdata = 32'h0BAD_0001;
        cnt1 = 0; cnt2 = 0; seen_if = 0;
        for (int i = 0; i < 60 && seen_if < 2; i++) begin
            step();
            if (if_gnt) seen_if++;
            if (d_gnt && seen_if == 0) cnt1++;
            if (d_gnt && seen_if == 1) cnt2++;
        end
        chk("starve_bound", seen_if, 2);
        chk("starve_first", cnt1, MD);
        chk("starve_after_clear", cnt2, MD);
        if_req = 1'b0; d_req = 1'b0;
        step(); step();
        mem_ready = 1'b0;
        step();

        // Timeout on a load
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        step();
        chk("to_d_gnt", 32'(d_gnt), 1);
        d_req = 1'b0;
        cnt1 = 1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (!mem_req) break;
            cnt1++;
        end
        chk("to_req_len", cnt1, TO);
        chk("to_d_valid", 32'(d_valid), 1);
        chk("to_d_err", 32'(d_err), 1);
        chk("to_d_rdata_kept", d_rdata, 32'h0BAD_0001);
        step();
        chk("to_busy_after", 32'(busy), 0);

        // Ready on the expiry edge completes normally
        d_req = 1'b1; d_addr = 32'h300;
        step();
        d_req = 1'b0;
        for (int i = 0; i < TO - 1; i++) step();
        chk("race_hold", 32'(mem_req), 1);
        mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
        step();
        chk("race_d_valid", 32'(d_valid), 1);
        chk("race_d_err", 32'(d_err), 0);
        chk("race_d_rdata", d_rdata, 32'h1234_5678);
        mem_ready = 1'b0;
        step();

        // Reset in the middle of a data access
        d_req = 1'b1; d_addr = 32'h500;
        step();
        d_req = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk("rstmid_mem_req", 32'(mem_req), 0);
        chk("rstmid_busy", 32'(busy), 0);
        chk("rstmid_d_rdata", d_rdata, 32'h0);
        chk("rstmid_mem_addr", mem_addr, 32'h0);
        rst = 1'b1; mem_ready = 1'b1;
        step();
        chk("rstmid_no_valid", 32'(d_valid), 0);
        mem_ready = 1'b0; if_req = 1'b1; if_addr = 32'h40;
        step();
        chk("rstmid_if_gnt", 32'(if_gnt), 1);
        if_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h00A0_0113;
        step();
        chk("rstmid_if_rdata", if_rdata, 32'h00A0_0113);
        mem_ready = 1'b0;
        step();

        // Randomised traffic against the model
        stall_left = 0;
        for (int i = 0; i < 4000; i++) begin
            if (!if_req) begin
                if ($urandom_range(0, 2) == 0) begin if_req = 1'b1; if_addr = $urandom; end
            end else if (e_if_gnt) begin
                if ($urandom_range(0, 1) == 0) if_req = 1'b0;
                else if_addr = $urandom;
            end
            if (!d_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
                    d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom);
                end
            end else if (e_d_gnt) begin
                if ($urandom_range(0, 1) == 0) d_req = 1'b0;
                else begin d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom_range(0, 1)); end
            end
            if (stall_left > 0) begin
                mem_ready = 1'b0; stall_left--;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 39) == 0) stall_left = $urandom_range(10, 20);
            end
            mem_rdata = $urandom;
            rst = ($urandom_range(0, 299) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Sequencer and arbiter that shares one single-ported unified memory between the core's instruction-fetch path and its load/store path. It accepts level requests from both sides and serialises them onto a registered memory handshake. It returns read data with a one-cycle valid pulse and exposes a busy flag that the datapath uses to stall the PC and the register-file write. A watchdog aborts hung accesses, and a fairness counter stops load/store traffic from starving fetch.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 16, memory wait cycles before abort; 0 disables the watchdog
MAX_DGRANT, 4, consecutive data grants allowed while fetch waits

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
if_req  in  1  fetch request (level)
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  pulse: fetch request captured
if_valid  out  1  pulse: fetch complete
if_rdata  out  DATA_W  fetched instruction
if_err  out  1  pulse with if_valid: fetch timed out
d_req  in  1  load/store request (level)
d_we  in  1  1 = store
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_be  in  4  byte enables
d_gnt  out  1  pulse: data request captured
d_valid  out  1  pulse: data access complete
d_rdata  out  DATA_W  load data
d_err  out  1  pulse with d_valid: data access timed out
mem_req  out  1  memory request, held until accepted
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_be  out  4  memory byte enables
mem_ready  in  1  memory accept/complete
mem_rdata  in  DATA_W  memory read data
busy  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. rst low overrides everything on the same edge. An outstanding access is abandoned: no valid and no err for it.
- States:
  - IDLE
    - If any request is pending, pick a winner at the edge.
    - Latch the winner's attributes into the mem_* registers; set mem_req=1.
    - Pulse the winner's gnt for exactly one cycle.
    - Go to I_WAIT or D_WAIT.
  - I_WAIT / D_WAIT
    - Hold mem_* stable. Increment wd_cnt each edge without mem_ready.
    - On an edge with mem_ready=1:
      - mem_req=0.
      - Capture mem_rdata into if_rdata (I_WAIT), or into d_rdata for a load (D_WAIT).
      - Pulse the matching valid for one cycle; go to IDLE.
    - Stores do not update d_rdata.
- Latency: capture edge E0 → mem_req high after E0. mem_ready sampled at edge Ek (k≥1) → valid high during the cycle after Ek.
  - Minimum request-to-valid is 2 cycles.
  - Maximum throughput is one access per 2 cycles, because IDLE is always revisited.
- Arbitration:
  - Data wins ties, since it belongs to the older instruction, unless starve_cnt==MAX_DGRANT; then fetch wins.
  - starve_cnt increments on each data grant made while if_req=1, saturates at MAX_DGRANT, and clears on any fetch grant.
- Requester rules:
  - Attributes must be stable while req=1 and before gnt.
  - Requesters may drop req after gnt.
  - A req still high in the cycle of its own valid is treated as a new request.
- Watchdog (TIMEOUT>0):
  - wd_cnt clears on entry to a WAIT state.
  - On reaching TIMEOUT-1 with mem_ready=0 at an edge: mem_req=0, pulse valid+err for the owner, rdata unchanged, go to IDLE.
  - mem_ready=1 on the threshold edge means normal completion with err=0.
- mem_ready while in IDLE is ignored.
- Widths: wd_cnt and starve_cnt are sized by $clog2 of their parameter plus 1. No wrap is possible because both saturate or clear.

Decomposition:
- defines.v gains:
  - state encodings `ARB_IDLE, `ARB_IWAIT, `ARB_DWAIT (2-bit).
  - requester IDs `REQ_IF, `REQ_D.
- One sub-module, mem_watchdog: parameterised TIMEOUT, inputs clr/en, output expired.
- Arbitration, the FSM and the mem_* registers stay in mem_port_arbiter.

Test Plan:
- Lone fetch: if_req with if_addr=0x0000_0010 at E0; mem_ready=1 at E3 with mem_rdata=0x0050_0093 → if_gnt after E0; mem_req high E0–E3; if_valid=1 and if_rdata=0x0050_0093 for one cycle after E3; if_err=0.
- Tie: if_req and d_req together, d_we=1, d_addr=0x100, d_wdata=0xDEAD_BEEF, d_be=0xF → data served first with mem_we=1 and mem_addr=0x100; d_rdata unchanged; fetch granted on the next IDLE edge.
- Starvation (MAX_DGRANT=4): if_req held while d_req is re-asserted continuously with mem_ready=1 every access → exactly 4 d_gnt pulses, then if_gnt; starve_cnt returns to 0.
- Timeout (TIMEOUT=16): load with mem_ready tied 0 → mem_req high 16 cycles then drops; d_valid=d_err=1 for one cycle; busy=0 afterwards.
- Threshold race: mem_ready=1 on the watchdog expiry edge with rdata=0x1234_5678 → d_valid=1, d_err=0, d_rdata=0x1234_5678.
- Reset mid-access: rst=0 for one edge during D_WAIT → next cycle all outputs 0 and no d_valid; a subsequent fetch completes normally.
